mult_arbiter: RTL
=================

Name: mult_arbiter

Overview:
- Shares one combinational unsigned WIDTH x WIDTH multiplier (the `mult` instance) among NREQ requesters.
- Round-robin arbitration; valid/ready handshake on each request port and on the single response port.
- Two-stage pipeline: operand register, then product register. The response is tagged with the requester index.
- Sits between the input shift-register front-end and the `mult` instance, and drives `mult` operands directly.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width; the product is 2*WIDTH.
- IDW, 2, width of the requester id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  issue enable; low blocks new grants while the pipeline still drains.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester grant; combinational, at most one bit set.
- req_a  input  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B, same packing as req_a.
- mul_a  output  WIDTH  registered operand A to `mult`.
- mul_b  output  WIDTH  registered operand B to `mult`.
- mul_p  input  2*WIDTH  combinational product returned from `mult`.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_data  output  2*WIDTH  product.
- rsp_id  output  IDW  index of the requester that issued the operation.

Behaviour:
- Reset (asynchronous, rst_n low):
  - v1, v2, rsp_valid, mul_a, mul_b, rsp_data, rsp_id, s1_id and rr_ptr all clear to 0.
  - req_ready is all 0 while rst_n is low.
  - In-flight operations are discarded. There is no response for them after reset.
- Pipeline registers:
  - S1 holds v1, mul_a, mul_b and s1_id.
  - S2 holds v2 (equal to rsp_valid), rsp_data and rsp_id.
- Stall logic:
  - adv2 = v1 & (~v2 | rsp_ready).
  - adv1 = ~v1 | adv2.
- Grant:
  - When en & adv1, grant the first requester with req_valid set, searching from rr_ptr upward modulo NREQ.
  - req_ready[g] = 1 in that same cycle.
  - A handshake is req_valid[g] & req_ready[g].
- On handshake at a clock edge:
  - mul_a <= req_a[g], mul_b <= req_b[g], s1_id <= g, v1 <= 1.
  - rr_ptr <= (g+1) mod NREQ.
- No handshake but adv2: v1 <= 0. mul_a and mul_b hold their values; they are not cleared.
- On adv2: rsp_data <= mul_p, rsp_id <= s1_id, v2 <= 1.
- On rsp_valid & rsp_ready with no adv2: v2 <= 0.
- rr_ptr changes only on a handshake.
- Latency: a handshake at edge N gives rsp_valid high after edge N+1 when there is no backpressure. Throughput is one operation per cycle.
- Backpressure:
  - With rsp_ready low, S2 holds, then S1 fills, then req_ready stays all 0.
  - At most 2 operations are in flight.
  - rsp_data and rsp_id are stable while rsp_valid & ~rsp_ready.
- Requester obligations:
  - Once req_valid is asserted, hold it and the operands stable until the handshake.
  - A requester with req_valid low is skipped.
- Empty: with no req_valid set or en low, the pipeline drains and rsp_valid drops after the last accepted response.
- Simultaneous events: in the same cycle, a response is consumed, S1 moves to S2 and a new grant loads S1, all without a bubble.
- Arithmetic: the product is entirely from mul_p, unsigned 2*WIDTH. The block performs no truncation.

Test Plan:
- Single multiply:
  - Stimulus: reset, then requester 2 presents a=0x0F, b=0x11, rsp_ready=1.
  - Required: req_ready=4'b0100 on the first cycle.
  - Required: exactly one rsp_valid cycle after 1 edge, with rsp_data=0x00FF and rsp_id=2.
- Round robin:
  - Stimulus: all 4 requesters continuously valid, with requester i giving a=b=i+1, rsp_ready=1.
  - Required: grant order 0,1,2,3,0,...
  - Required: responses 1,4,9,16 back-to-back with ids 0..3, no bubbles.
- Backpressure:
  - Stimulus: rsp_ready=0, requesters 0 and 1 valid (0xFF x 0xFF, 0x02 x 0x03).
  - Required: two grants, then req_ready=0.
  - Required: rsp_data holds 0xFE01 with id 0.
  - Stimulus: raise rsp_ready.
  - Required: 0xFE01/id0, then 0x0006/id1, on consecutive cycles.
- Enable gating:
  - Stimulus: en=0 with requester 3 valid.
  - Required: req_ready stays 0 for 10 cycles and no rsp_valid.
  - Stimulus: en=1.
  - Required: grant on the same cycle as en=1.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously (between edges) while v1 and v2 are both set.
  - Required: rsp_valid, mul_a and mul_b go to 0 immediately.
  - Required: after release, with no requests, rsp_valid stays 0 and the first grant goes to requester 0.
- Skip idle requester:
  - Stimulus: rr_ptr=1 (after a grant to 0), only requesters 0 and 3 valid.
  - Required: grant to 3, then to 0.

Source files
------------

// File: rtl/mult_arbiter.sv
// mult_arbiter
// ------------
// Shares one external combinational multiplier among NREQ requesters.
// A round-robin arbiter picks one valid requester per cycle. The chosen
// operands go into a first register stage that drives the multiplier
// directly. The returned product is captured in a second register stage,
// together with the id of the requester that issued it.
// Both stages stall under response backpressure, so at most two operations
// are in flight at any time.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (discards in-flight work)
//   en         issue enable; low blocks new grants while the pipe drains
//   req_valid  per-requester request valid                   [NREQ]
//   req_ready  per-requester grant, combinational, one-hot   [NREQ]
//   req_a/b    packed operands, requester i at [i*WIDTH +: WIDTH]
//   mul_a/b    registered operands to the multiplier         [WIDTH]
//   mul_p      product returned by the multiplier            [2*WIDTH]
//   rsp_valid  response valid
//   rsp_ready  response consumer ready
//   rsp_data   product                                       [2*WIDTH]
//   rsp_id     index of the issuing requester                [IDW]

module mult_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  logic [2*WIDTH-1:0]      mul_p,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2*WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]          rsp_id
);

    // Stage 1: operand register
    logic                 v1_q, v1_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
    logic [IDW-1:0]       s1_id_q, s1_id_d;

    // Stage 2: product register
    logic                 v2_q, v2_d;
    logic [2*WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [IDW-1:0]       rsp_id_q, rsp_id_d;

    // Round-robin pointer: the requester searched first
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;

    logic                 adv1, adv2;
    logic                 found;
    logic                 hs;
    logic [IDW-1:0]       gnt_idx;
    logic [WIDTH-1:0]     sel_a, sel_b;
    int                   j;

    // S2 accepts S1 when it is empty or its content leaves this cycle.
    // S1 accepts a new operation when it is empty or drains into S2.
    assign adv2 = v1_q & (~v2_q | rsp_ready);
    assign adv1 = ~v1_q | adv2;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && req_valid[j]) begin
                found   = 1'b1;
                gnt_idx = IDW'(j);
            end
        end
    end

    // A grant is only offered when it will be taken, so a grant is a handshake.
    // rst_n gates it so that no requester sees ready while the block is in reset.
    assign hs        = rst_n & en & adv1 & found;
    assign req_ready = hs ? (NREQ'(1) << gnt_idx) : '0;

    assign sel_a = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
    assign sel_b = req_b[int'(gnt_idx)*WIDTH +: WIDTH];

    always_comb begin
        v1_d       = v1_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        s1_id_d    = s1_id_q;
        v2_d       = v2_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        rr_ptr_d   = rr_ptr_q;

        if (hs) begin
            v1_d     = 1'b1;
            mul_a_d  = sel_a;
            mul_b_d  = sel_b;
            s1_id_d  = gnt_idx;
            rr_ptr_d = (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + IDW'(1);
        end else if (adv2) begin
            // The operands are left in place. Only the valid bit drops.
            v1_d = 1'b0;
        end

        if (adv2) begin
            v2_d       = 1'b1;
            rsp_data_d = mul_p;
            rsp_id_d   = s1_id_q;
        end else if (v2_q && rsp_ready) begin
            v2_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments, so every flop
    // samples values from before the edge, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q       <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            s1_id_q    <= '0;
            v2_q       <= 1'b0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            rr_ptr_q   <= '0;
        end else begin
            v1_q       <= v1_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            s1_id_q    <= s1_id_d;
            v2_q       <= v2_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = v2_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule
